// File: rtl/tft_pixel_fetch.sv
// Frame fetcher: bursts pixel words from memory into a show-ahead FIFO feeding a TFT panel.
// Optional underflow event counter is built when TFT_FETCH_UFCNT_EN is defined.
module tft_pixel_fetch #(
    parameter logic [23:0] BASE_ADDR    = 24'h000000,
    parameter int unsigned FRAME_PIXELS = 360960,
    parameter int unsigned BURST_LEN    = 16,
    parameter int unsigned FIFO_DEPTH   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tft_request,
    input  logic        tft_vsync,
    output logic [23:0] pixel_data,
    output logic        rd_req,
    output logic [23:0] rd_addr,
    output logic [7:0]  rd_len,
    input  logic        rd_ack,
    input  logic        rd_valid,
    input  logic [23:0] rd_data,
    output logic        underflow,
    output logic [15:0] underflow_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(FRAME_PIXELS + 1);

    typedef enum logic [1:0] {IDLE, REQ, RECV, DRAIN} state_t;

    state_t        state;
    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, level, level_next;
    logic [WW-1:0] words_left;
    logic [7:0]    beats_left, next_len, beats_rem;
    logic          vsync_q, vs_fall, empty, full, push, pop, can_issue;

    assign level      = wr_ptr - rd_ptr;
    assign empty      = (level == '0);
    assign full       = level[AW];
    assign vs_fall    = vsync_q & ~tft_vsync;
    // A flush cycle overrides any push or pop happening alongside it.
    assign pop        = tft_request & ~empty & ~vs_fall;
    assign push       = rd_valid & (state == RECV) & ~vs_fall & ~full;
    assign level_next = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign pixel_data = empty ? 24'h000000 : mem[rd_ptr[AW-1:0]];
    assign beats_rem  = beats_left - {7'd0, rd_valid};

    always_comb begin
        next_len = 8'(BURST_LEN);
        if (32'(words_left) < BURST_LEN)
            next_len = 8'(words_left);
    end

    // Requests are only issued with no beats outstanding, so the credit is level plus this burst.
    assign can_issue = (words_left != '0) &&
                       (32'(level_next) + 32'(next_len) <= FIFO_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_req     <= 1'b0;
            rd_addr    <= BASE_ADDR;
            rd_len     <= 8'd0;
            words_left <= WW'(FRAME_PIXELS);
            beats_left <= 8'd0;
        end else if (vs_fall) begin
            rd_req     <= 1'b0;
            rd_addr    <= BASE_ADDR;
            words_left <= WW'(FRAME_PIXELS);
            case (state)
                REQ: begin
                    if (rd_ack) begin
                        beats_left <= rd_len;
                        state      <= DRAIN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RECV, DRAIN: begin
                    beats_left <= beats_rem;
                    state      <= (beats_rem == 8'd0) ? IDLE : DRAIN;
                end
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (can_issue) begin
                        rd_req <= 1'b1;
                        rd_len <= next_len;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (rd_ack) begin
                        rd_req     <= 1'b0;
                        rd_addr    <= rd_addr + {16'h0000, rd_len};
                        words_left <= words_left - WW'(rd_len);
                        beats_left <= rd_len;
                        state      <= RECV;
                    end
                end
                RECV: begin
                    if (rd_valid) begin
                        beats_left <= beats_rem;
                        if (beats_left == 8'd1) begin
                            if (can_issue) begin
                                rd_req <= 1'b1;
                                rd_len <= next_len;
                                state  <= REQ;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (rd_valid) begin
                        beats_left <= beats_rem;
                        if (beats_left == 8'd1)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            vsync_q   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            vsync_q <= tft_vsync;
            if (tft_request && empty)
                underflow <= 1'b1;
            if (vs_fall) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= rd_data;
    end

`ifdef TFT_FETCH_UFCNT_EN
    logic [15:0] uf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            uf_cnt <= 16'h0000;
        else if (tft_request && empty && uf_cnt != 16'hFFFF)
            uf_cnt <= uf_cnt + 16'd1;
    end

    assign underflow_cnt = uf_cnt;
`else
    assign underflow_cnt = 16'h0000;
`endif

endmodule

// File: doc/tft_pixel_fetch.md
TFT_PIXEL_FETCH -- requirements
Module: tft_pixel_fetch

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 24'h000000: word address of the first pixel of the frame.
REQ-002 SHALL have parameter FRAME_PIXELS, default 360960 (752x480): words fetched per frame.
REQ-003 SHALL have parameter BURST_LEN, default 16: maximum words per read burst, range 1..255.
REQ-004 SHALL have parameter FIFO_DEPTH, default 64: power of 2, at least 2*BURST_LEN.
REQ-005 SHALL have port clk, input, 1: single clock (33.3 MHz), all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port tft_request, input, 1: display pixel request; each high cycle consumes one pixel.
REQ-008 SHALL have port tft_vsync, input, 1: display vertical sync, low during the sync interval.
REQ-009 SHALL have port pixel_data, output, 24: RGB pixel for the display, valid in the same cycle as tft_request.
REQ-010 SHALL have port rd_req, output, 1: memory burst request.
REQ-011 SHALL have port rd_addr, output, 24: burst start word address.
REQ-012 SHALL have port rd_len, output, 8: burst length in words.
REQ-013 SHALL have port rd_ack, input, 1: one-cycle acceptance of rd_req.
REQ-014 SHALL have port rd_valid, input, 1: read data beat strobe.
REQ-015 SHALL have port rd_data, input, 24: read data beat.
REQ-016 SHALL have port underflow, output, 1: sticky flag, set when tft_request is high while the FIFO is empty.
REQ-017 SHALL have port underflow_cnt, output, 16: underflow event count (see Configuration).

Function
REQ-018 SHALL buffer rd_data in a show-ahead FIFO of FIFO_DEPTH words, with pixel_data driven combinationally from the FIFO head.
REQ-019 SHALL pop one word in each cycle that tft_request is high and the FIFO is not empty.
REQ-020 SHALL drive pixel_data to 24'h000000 whenever the FIFO is empty.
REQ-021 SHALL push rd_data on each rd_valid; when a push and a pop occur in the same cycle, the FIFO level SHALL be unchanged.
REQ-022 SHALL implement an FSM with states IDLE, REQ, RECV and DRAIN.
REQ-023 In IDLE, SHALL move to REQ when words_left > 0 and (FIFO level + outstanding beats) <= FIFO_DEPTH - rd_len.
REQ-024 SHALL set rd_len = min(BURST_LEN, words_left) and hold rd_req, rd_addr and rd_len stable in REQ until rd_ack.
REQ-025 On rd_ack, SHALL add rd_len to rd_addr, subtract rd_len from words_left, and go to RECV.
REQ-026 In RECV, SHALL count rd_valid beats and return to IDLE after rd_len beats, with no idle cycle required before the next request.
REQ-027 On a tft_vsync falling edge (registered 1->0), SHALL flush the FIFO, set rd_addr = BASE_ADDR and words_left = FRAME_PIXELS, and leave underflow unchanged.
REQ-028 If the vsync falling edge occurs in REQ, SHALL drop rd_req in the next cycle and go to IDLE; an rd_ack in the edge cycle itself SHALL be treated as accepted and the FSM SHALL go to DRAIN.
REQ-029 If the vsync falling edge occurs in RECV, SHALL go to DRAIN, discard the remaining beats of that burst, then go to IDLE.
REQ-030 SHALL issue no new request while words_left = 0, and pops SHALL continue until the FIFO is empty.
REQ-031 An rd_valid arriving while the FIFO is full SHALL be dropped; the credit rule in REQ-023 makes this unreachable, and the bench SHALL check it never occurs.

Reset
REQ-032 While rst_n is low, SHALL set: FSM = IDLE, FIFO empty, rd_req = 0, rd_addr = BASE_ADDR, rd_len = 0, words_left = FRAME_PIXELS, pixel_data = 0, underflow = 0, underflow_cnt = 0.
REQ-033 A reset asserted mid-burst SHALL abort the burst immediately, and beats arriving after reset release without a new rd_ack SHALL be ignored.

Configuration
REQ-034 With TFT_FETCH_UFCNT_EN defined, underflow_cnt SHALL increment by 1 per underflow cycle, saturate at 16'hFFFF, and clear only on reset.
REQ-035 Without TFT_FETCH_UFCNT_EN, underflow_cnt SHALL be tied to 16'h0000 and the counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-036 After reset, with rd_ack returned 2 cycles after rd_req: first request SHALL show rd_addr = 0 and rd_len = 16; a second request with rd_addr = 16 SHALL follow before the FIFO exceeds 64 words.
REQ-037 With FRAME_PIXELS = 40 and BURST_LEN = 16: SHALL issue exactly three requests, with rd_len = 16, 16, 8 and rd_addr = 0, 16, 32, then stay in IDLE.
REQ-038 With the FIFO holding 5 words and tft_request high for 8 cycles: pixel_data SHALL equal words 0..4, then 0 for 3 cycles; underflow SHALL be 1; underflow_cnt SHALL be 3 with the macro and 0 without.
REQ-039 With a tft_vsync falling edge after 6 of 16 beats: SHALL discard the remaining 10 beats, leave the FIFO empty, and issue the next request with rd_addr = BASE_ADDR.
REQ-040 With a simultaneous rd_valid and pop at level 10: level SHALL stay 10 and the data order SHALL be preserved.
REQ-041 With rst_n pulsed low during RECV: all outputs SHALL take their REQ-032 values asynchronously, and late beats SHALL not enter the FIFO.
